// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler: FSM states, op-code
// limits, the ALU phase codes and a helper for addressing packed per-requester ports.
package alu_sched_pkg;

   localparam int ALU_WIDTH   = 8;
   localparam int ALU_OPS     = 16;
   localparam int CPU_STATES  = 8;
   localparam int CPU_STATE_W = $clog2(CPU_STATES);

   // Phase codes understood by the ALU interface block.
   localparam logic [CPU_STATE_W-1:0] EXECUTE1 = 3'd2;
   localparam logic [CPU_STATE_W-1:0] EXECUTE2 = 3'd3;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_LAST = 4'b1001;
   localparam logic [3:0] OP_CMP  = 4'b1001;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXEC,
      RESP
   } sched_state_e;

   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins. The pointer register lives in the instantiating block.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]                         req,
   input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
   output logic [NREQ-1:0]                         grant,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;
   logic           found;

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and no latch is inferred.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDW + 1)'(k);
         if (sum >= (IDW + 1)'(NREQ)) begin
            sum = sum - (IDW + 1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU interface between NREQ requesters: round-robin grant, then the
// two-phase EXECUTE1/EXECUTE2 sequence, then a held response to the winner.
module alu_req_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = $clog2(ALU_OPS)
) (
   input  logic                     sys_clk,
   input  logic                     sys_reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   input  logic [NREQ*OPW-1:0]      req_op,
   output logic [NREQ-1:0]          resp_valid,
   input  logic [NREQ-1:0]          resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     resp_gt,
   output logic                     resp_eq,
   output logic                     resp_err,
   output logic [WIDTH-1:0]         A_bus,
   output logic [WIDTH-1:0]         B_bus,
   output logic                     alu_en_A_reg,
   output logic                     alu_en_B_reg,
   output logic [OPW-1:0]           alu_op,
   output logic [CPU_STATE_W-1:0]   cpu_state,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic                     cc_greater,
   input  logic                     cc_equal
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_e     state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [OPW-1:0]   op_q;
   logic             err_q;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_id;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [OPW-1:0]   sel_op;
   logic             sel_err;
   logic             accept;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .grant   (grant),
      .grant_id(grant_id)
   );

   assign sel_a   = req_a[slice_lo(int'(grant_id), WIDTH) +: WIDTH];
   assign sel_b   = req_b[slice_lo(int'(grant_id), WIDTH) +: WIDTH];
   assign sel_op  = req_op[slice_lo(int'(grant_id), OPW) +: OPW];
   assign sel_err = (sel_op > OPW'(OP_LAST));
   assign accept  = (state_q == IDLE) && (|req_valid);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      req_ready    = '0;
      resp_valid   = '0;
      resp_data    = '0;
      resp_gt      = 1'b0;
      resp_eq      = 1'b0;
      resp_err     = 1'b0;
      A_bus        = '0;
      B_bus        = '0;
      alu_en_A_reg = 1'b0;
      alu_en_B_reg = 1'b0;
      alu_op       = '0;
      cpu_state    = EXECUTE1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               req_ready = grant;
               rr_ptr_d  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
               // Illegal ops skip the ALU entirely and answer with an error.
               state_d   = sel_err ? RESP : LOAD;
            end
         end
         LOAD: begin
            cpu_state    = EXECUTE1;
            alu_en_A_reg = 1'b1;
            alu_en_B_reg = 1'b1;
            A_bus        = a_q;
            B_bus        = b_q;
            alu_op       = op_q;
            state_d      = EXEC;
         end
         EXEC: begin
            cpu_state    = EXECUTE2;
            alu_en_A_reg = 1'b1;
            alu_en_B_reg = 1'b1;
            A_bus        = a_q;
            B_bus        = b_q;
            alu_op       = op_q;
            state_d      = RESP;
         end
         RESP: begin
            resp_valid[id_q] = 1'b1;
            if (err_q) begin
               resp_err = 1'b1;
            end else begin
               // The ALU is idle in RESP, so its registered outputs hold steady.
               resp_data = alu_result;
               resp_gt   = cc_greater;
               resp_eq   = cc_equal;
            end
            if (resp_ready[id_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // NOTE: the captured payload is only read in LOAD/EXEC/RESP, which are
   // reachable only after a capture, so these registers need no reset.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         a_q   <= sel_a;
         b_q   <= sel_b;
         op_q  <= sel_op;
         err_q <= sel_err;
         id_q  <= grant_id;
      end
   end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler with a behavioural two-phase ALU
// and a response scoreboard.
module tb_alu_req_scheduler;
   import alu_sched_pkg::*;

   localparam int NREQ = 2;
   localparam int W    = ALU_WIDTH;
   localparam int OPW  = 4;

   logic                   sys_clk = 1'b0;
   logic                   sys_reset = 1'b1;
   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*W-1:0]      req_a = '0;
   logic [NREQ*W-1:0]      req_b = '0;
   logic [NREQ*OPW-1:0]    req_op = '0;
   logic [NREQ-1:0]        resp_valid;
   logic [NREQ-1:0]        resp_ready = '1;
   logic [W-1:0]           resp_data;
   logic                   resp_gt, resp_eq, resp_err;
   logic [W-1:0]           A_bus, B_bus;
   logic                   alu_en_A_reg, alu_en_B_reg;
   logic [OPW-1:0]         alu_op;
   logic [CPU_STATE_W-1:0] cpu_state;
   logic [W-1:0]           alu_result = '0;
   logic                   cc_greater = 1'b0;
   logic                   cc_equal = 1'b0;

   alu_req_scheduler #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW)) dut (
      .sys_clk(sys_clk), .sys_reset(sys_reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_gt(resp_gt), .resp_eq(resp_eq), .resp_err(resp_err),
      .A_bus(A_bus), .B_bus(B_bus),
      .alu_en_A_reg(alu_en_A_reg), .alu_en_B_reg(alu_en_B_reg),
      .alu_op(alu_op), .cpu_state(cpu_state),
      .alu_result(alu_result), .cc_greater(cc_greater), .cc_equal(cc_equal)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [NREQ-1:0] vld;
      logic [W-1:0]    data;
      logic            gt;
      logic            eq;
      logic            err;
   } resp_t;

   resp_t sb_q[$];
   resp_t mon_got, mon_exp;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;

   function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a, b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return ~a;
         4'd7:    return a << 1;
         4'd8:    return a >> 1;
         default: return '0;
      endcase
   endfunction

   function automatic resp_t expect_of(input int id, input logic [W-1:0] a, b, input logic [OPW-1:0] op);
      resp_t r;
      r.vld = NREQ'(1) << id;
      if (op > 4'b1001) begin
         r.data = '0; r.gt = 1'b0; r.eq = 1'b0; r.err = 1'b1;
      end else begin
         r.data = alu_fn(op, a, b); r.gt = (a > b); r.eq = (a == b); r.err = 1'b0;
      end
      return r;
   endfunction

   // Behavioural ALU: operands latched at the end of EXECUTE1, result and flags at the end of EXECUTE2.
   logic [W-1:0] alu_a = '0, alu_b = '0;
   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (alu_en_A_reg && cpu_state == EXECUTE1) alu_a <= A_bus;
      if (alu_en_B_reg && cpu_state == EXECUTE1) alu_b <= B_bus;
      if (alu_en_A_reg && alu_en_B_reg && cpu_state == EXECUTE2) begin
         alu_result <= alu_fn(alu_op, alu_a, alu_b);
         cc_greater <= (alu_a > alu_b);
         cc_equal   <= (alu_a == alu_b);
      end
   end

   // Scoreboard consumer: every completed response handshake pops one expectation.
   always @(negedge sys_clk) begin
      if (!sys_reset && (resp_valid & resp_ready) != '0) begin
         mon_got = {resp_valid, resp_data, resp_gt, resp_eq, resp_err};
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got=%h required=none", mon_got);
         end else begin
            mon_exp = sb_q.pop_front();
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL sb_resp: got=%h required=%h", mon_got, mon_exp);
            end
         end
      end
   end

   task automatic drive_req(input int id, input logic [W-1:0] a, b, input logic [OPW-1:0] op);
      req_a[id*W +: W]      = a;
      req_b[id*W +: W]      = b;
      req_op[id*OPW +: OPW] = op;
      req_valid[id]         = 1'b1;
   endtask

   task automatic reset_dut();
      @(posedge sys_clk); #1;
      sys_reset  = 1'b1;
      req_valid  = '0;
      resp_ready = '1;
      repeat (2) @(posedge sys_clk);
      #1 sys_reset = 1'b0;
   endtask

   // Issues one request and follows it to its response, reporting what was seen.
   task automatic run_req(input int id, input logic [W-1:0] a, b, input logic [OPW-1:0] op,
                          output logic [NREQ-1:0] rdy, output int lat, output int en_cyc, output resp_t seen);
      int n;
      @(posedge sys_clk); #1;
      drive_req(id, a, b, op);
      rdy = '0;
      n = 0;
      while (rdy == '0 && n < 20) begin
         @(negedge sys_clk);
         rdy = req_ready;
         n++;
      end
      if (rdy != '0) sb_q.push_back(expect_of(id, a, b, op));
      @(posedge sys_clk); #1;
      req_valid[id] = 1'b0;
      lat = -1;
      en_cyc = 0;
      seen = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge sys_clk);
         if (alu_en_A_reg || alu_en_B_reg) en_cyc++;
         if (resp_valid != '0) begin
            lat = k;
            seen = {resp_valid, resp_data, resp_gt, resp_eq, resp_err};
            break;
         end
      end
      @(posedge sys_clk); #1;
   endtask

   task automatic test_reset();
      sys_reset = 1'b1;
      repeat (2) @(negedge sys_clk);
      total++;
      if ({req_ready, resp_valid, resp_data, resp_gt, resp_eq, resp_err, A_bus, B_bus,
           alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state} !== {{(4*NREQ + 3*W + 5 + OPW){1'b0}}, EXECUTE1}) begin
         bad++;
         $display("FAIL reset_hold: rr=%b rv=%b d=%h A=%h B=%h en=%b%b op=%h ph=%h",
                  req_ready, resp_valid, resp_data, A_bus, B_bus, alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state);
      end
      @(posedge sys_clk); #1 sys_reset = 1'b0;
      @(negedge sys_clk);
      total++;
      if ({req_ready, resp_valid, resp_data, resp_err, alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state} !==
          {{(2*NREQ + W + 3 + OPW){1'b0}}, EXECUTE1}) begin
         bad++;
         $display("FAIL reset_idle: rr=%b rv=%b d=%h en=%b%b op=%h ph=%h required all zero, ph=%h",
                  req_ready, resp_valid, resp_data, alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state, EXECUTE1);
      end
   endtask

   task automatic test_add();
      logic [CPU_STATE_W-1:0] exp_ph;
      @(posedge sys_clk); #1;
      resp_ready = '1;
      drive_req(0, 8'h05, 8'h03, 4'b0001);
      @(negedge sys_clk);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL add_ready: got=%b required=01", req_ready);
      end
      sb_q.push_back(expect_of(0, 8'h05, 8'h03, 4'b0001));
      @(posedge sys_clk); #1;
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         exp_ph = (k == 1) ? EXECUTE1 : EXECUTE2;
         @(negedge sys_clk);
         total++;
         if ({alu_en_A_reg, alu_en_B_reg, cpu_state, A_bus, B_bus, alu_op, resp_valid} !==
             {2'b11, exp_ph, 8'h05, 8'h03, 4'h1, 2'b00}) begin
            bad++;
            $display("FAIL add_phase%0d: en=%b%b ph=%h A=%h B=%h op=%h rv=%b required en=11 ph=%h A=05 B=03 op=1 rv=00",
                     k, alu_en_A_reg, alu_en_B_reg, cpu_state, A_bus, B_bus, alu_op, resp_valid, exp_ph);
         end
      end
      @(negedge sys_clk);
      total++;
      if ({resp_valid, resp_data, resp_gt, resp_eq, resp_err} !== {2'b01, 8'h08, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL add_resp: rv=%b d=%h gt=%b eq=%b err=%b required rv=01 d=08 gt=1 eq=0 err=0",
                  resp_valid, resp_data, resp_gt, resp_eq, resp_err);
      end
      @(negedge sys_clk);
      total++;
      if ({resp_valid, alu_en_A_reg, alu_en_B_reg, A_bus, B_bus, alu_op, cpu_state} !==
          {{(NREQ + 2 + 2*W + OPW){1'b0}}, EXECUTE1}) begin
         bad++;
         $display("FAIL add_idle: rv=%b en=%b%b A=%h B=%h op=%h ph=%h",
                  resp_valid, alu_en_A_reg, alu_en_B_reg, A_bus, B_bus, alu_op, cpu_state);
      end
   endtask

   task automatic test_contention();
      int grants, last;
      logic [NREQ-1:0] exp_g;
      int gid;
      reset_dut();
      @(posedge sys_clk); #1;
      drive_req(0, 8'h11, 8'h22, 4'b0001);
      drive_req(1, 8'h40, 8'h04, 4'b0010);
      grants = 0;
      last = 0;
      for (int n = 0; n < 40 && grants < 4; n++) begin
         @(negedge sys_clk);
         if (req_ready != '0) begin
            exp_g = (grants % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (req_ready !== exp_g) begin
               bad++;
               $display("FAIL contention_grant%0d: got=%b required=%b", grants, req_ready, exp_g);
            end
            gid = req_ready[1] ? 1 : 0;
            if (gid == 0) sb_q.push_back(expect_of(0, 8'h11, 8'h22, 4'b0001));
            else          sb_q.push_back(expect_of(1, 8'h40, 8'h04, 4'b0010));
            if (grants > 0) begin
               total++;
               if (cyc - last != 4) begin
                  bad++;
                  $display("FAIL contention_spacing: got=%0d required=4", cyc - last);
               end
            end
            last = cyc;
            grants++;
         end
      end
      total++;
      if (grants != 4) begin
         bad++;
         $display("FAIL contention_timeout: grants=%0d required=4", grants);
      end
      @(posedge sys_clk); #1;
      req_valid = '0;
      repeat (6) @(posedge sys_clk);
   endtask

   task automatic test_compare();
      logic [NREQ-1:0] rdy; int lat, en_cyc; resp_t seen;
      run_req(1, 8'h07, 8'h03, 4'b1001, rdy, lat, en_cyc, seen);
      total++;
      if ({rdy, lat, en_cyc, seen} !== {2'b10, 32'd3, 32'd2, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL cmp_gt: rdy=%b lat=%0d en=%0d resp=%h required rdy=10 lat=3 en=2 resp=%h",
                  rdy, lat, en_cyc, seen, {2'b10, 8'h00, 3'b100});
      end
      run_req(0, 8'h2A, 8'h2A, 4'b1001, rdy, lat, en_cyc, seen);
      total++;
      if ({rdy, lat, seen} !== {2'b01, 32'd3, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL cmp_eq: rdy=%b lat=%0d resp=%h required rdy=01 lat=3 resp=%h",
                  rdy, lat, seen, {2'b01, 8'h00, 3'b010});
      end
   endtask

   task automatic test_illegal();
      logic [NREQ-1:0] rdy; int lat, en_cyc; resp_t seen;
      run_req(1, 8'h55, 8'hAA, 4'b1111, rdy, lat, en_cyc, seen);
      total++;
      if ({lat, en_cyc, seen} !== {32'd1, 32'd0, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL illegal_op: lat=%0d en=%0d resp=%h required lat=1 en=0 resp=%h",
                  lat, en_cyc, seen, {2'b10, 8'h00, 3'b001});
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(posedge sys_clk); #1;
      resp_ready = '0;
      drive_req(0, 8'h10, 8'h01, 4'b0010);
      @(negedge sys_clk);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL bp_ready: got=%b required=01", req_ready);
      end
      sb_q.push_back(expect_of(0, 8'h10, 8'h01, 4'b0010));
      @(posedge sys_clk); #1;
      req_valid[0] = 1'b0;
      drive_req(1, 8'h03, 8'h09, 4'b0011);
      n = 0;
      while (resp_valid == '0 && n < 10) begin
         @(negedge sys_clk);
         n++;
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL bp_latency: got=%0d required=3", n);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge sys_clk);
         total++;
         if ({resp_valid, resp_data, req_ready} !== {2'b01, 8'h0F, 2'b00}) begin
            bad++;
            $display("FAIL bp_hold%0d: rv=%b d=%h rr=%b required rv=01 d=0f rr=00", k, resp_valid, resp_data, req_ready);
         end
      end
      @(posedge sys_clk); #1;
      resp_ready = '1;
      @(negedge sys_clk);
      total++;
      if ({resp_valid, req_ready} !== {2'b01, 2'b00}) begin
         bad++;
         $display("FAIL bp_handshake: rv=%b rr=%b required rv=01 rr=00", resp_valid, req_ready);
      end
      @(negedge sys_clk);
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL bp_next_accept: got=%b required=10", req_ready);
      end
      sb_q.push_back(expect_of(1, 8'h03, 8'h09, 4'b0011));
      @(posedge sys_clk); #1;
      req_valid = '0;
      repeat (5) @(posedge sys_clk);
   endtask

   task automatic test_reset_in_exec();
      @(posedge sys_clk); #1;
      drive_req(0, 8'h21, 8'h12, 4'b0001);
      @(negedge sys_clk);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL rst_pre_grant: got=%b required=01", req_ready);
      end
      @(posedge sys_clk); #1;
      req_valid = '0;
      @(posedge sys_clk); #1;
      sys_reset = 1'b1;
      @(negedge sys_clk);
      total++;
      if ({alu_en_A_reg, cpu_state} !== {1'b1, EXECUTE2}) begin
         bad++;
         $display("FAIL rst_in_exec: en=%b ph=%h required en=1 ph=%h", alu_en_A_reg, cpu_state, EXECUTE2);
      end
      @(posedge sys_clk); #1;
      sys_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         total++;
         if ({req_ready, resp_valid, resp_data, resp_gt, resp_eq, resp_err, A_bus, B_bus,
              alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state} !== {{(4*NREQ + 3*W + 5 + OPW){1'b0}}, EXECUTE1}) begin
            bad++;
            $display("FAIL rst_after%0d: rr=%b rv=%b d=%h err=%b A=%h B=%h en=%b%b op=%h ph=%h", k,
                     req_ready, resp_valid, resp_data, resp_err, A_bus, B_bus, alu_en_A_reg, alu_en_B_reg, alu_op, cpu_state);
         end
      end
      @(posedge sys_clk); #1;
      drive_req(0, 8'h30, 8'h0C, 4'b0101);
      drive_req(1, 8'h01, 8'h02, 4'b0001);
      @(negedge sys_clk);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL rst_fresh_grant: got=%b required=01", req_ready);
      end
      sb_q.push_back(expect_of(0, 8'h30, 8'h0C, 4'b0101));
      @(posedge sys_clk); #1;
      req_valid = '0;
      repeat (5) @(posedge sys_clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_contention();
      test_compare();
      test_illegal();
      test_backpressure();
      test_reset_in_exec();
      repeat (3) @(negedge sys_clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got=%0d pending required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
